// File: rtl/loop_ctrl.sv
// Loop sequencer for the BeeF PC: loop-open/close resolution via a hardware
// return stack, plus a forward skip scan over loop bodies entered with a zero cell.
module loop_ctrl #(
  parameter int PCWidth   = 16,
  parameter int Depth     = 16,
  parameter int SkipWidth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic [PCWidth-1:0]         pc,
  input  logic                       loop_open,
  input  logic                       loop_close,
  input  logic                       cell_zero,
  output logic                       pc_load,
  output logic [PCWidth-1:0]         pc_target,
  output logic                       skip,
  output logic                       halt,
  output logic [1:0]                 err_code,
  output logic [$clog2(Depth+1)-1:0] depth
);

  localparam int DW = $clog2(Depth + 1);
  localparam int AW = $clog2(Depth);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SKIP = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic [SkipWidth-1:0] skipCnt_q, skipCnt_d;
  logic [1:0]           err_q, err_d;
  logic [PCWidth-1:0]   stack_q [Depth];
  logic                 push;
  logic [DW-1:0]        topIdx;

  assign topIdx = depth_q - DW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      depth_q   <= '0;
      skipCnt_q <= '0;
      err_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      skipCnt_q <= skipCnt_d;
      err_q     <= err_d;
    end
  end

  // Stack storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[depth_q[AW-1:0]] <= pc;
    end
  end

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    skipCnt_d = skipCnt_q;
    err_d     = err_q;
    push      = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    skip      = (state_q != RUN);

    if (reset) begin
      skip = 1'b0;
    end else if (step) begin
      unique case (state_q)
        RUN: begin
          if (loop_open && loop_close) begin
            state_d = HALT;
            err_d   = 2'd3;
            skip    = 1'b1;
          end else if (loop_open) begin
            if (cell_zero) begin
              skip      = 1'b1;
              skipCnt_d = SkipWidth'(1);
              state_d   = SKIP;
            end else if (depth_q == DW'(Depth)) begin
              state_d = HALT;
              err_d   = 2'd1;
              skip    = 1'b1;
            end else begin
              push    = 1'b1;
              depth_d = depth_q + DW'(1);
            end
          end else if (loop_close) begin
            if (depth_q == '0) begin
              state_d = HALT;
              err_d   = 2'd2;
              skip    = 1'b1;
            end else if (!cell_zero) begin
              pc_load   = 1'b1;
              pc_target = stack_q[topIdx[AW-1:0]] + PCWidth'(1);
            end else begin
              depth_d = topIdx;
            end
          end
        end
        SKIP: begin
          // The close that brings the nesting count to zero is itself skipped.
          if (loop_open && loop_close) begin
            state_d = HALT;
            err_d   = 2'd3;
          end else if (loop_open) begin
            if (&skipCnt_q) begin
              state_d = HALT;
              err_d   = 2'd3;
            end else begin
              skipCnt_d = skipCnt_q + SkipWidth'(1);
            end
          end else if (loop_close) begin
            skipCnt_d = skipCnt_q - SkipWidth'(1);
            if (skipCnt_q == SkipWidth'(1)) begin
              state_d = RUN;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign halt     = (state_q == HALT);
  assign err_code = err_q;
  assign depth    = depth_q;

endmodule

// File: doc/loop_ctrl.md
Name: loop_ctrl

Overview:
- Loop sequencer for the BeeF core's program counter.
- Decides, per retired instruction, whether the PC increments or loads a jump target for loop-open/loop-close instructions, using a hardware return-address stack.
- Runs a forward skip scan over loop bodies whose cell is zero, so the PC never needs a precomputed branch offset.
- Sits between the instruction decoder and the PC source mux; pc_load/pc_target drive the mux select and load operand.

Parameters:
- PCWidth, 16, width of PC and stack entries
- Depth, 16, return-stack entries (power of 2, >=2)
- SkipWidth, 8, width of skip-scan nesting counter

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- step  input  1  instruction at pc retires this cycle; no state change when low
- pc  input  PCWidth  address of current instruction
- loop_open  input  1  decoded: current instruction is loop-open
- loop_close  input  1  decoded: current instruction is loop-close
- cell_zero  input  1  current data cell == 0
- pc_load  output  1  combinational: 1 = PC loads pc_target next edge, 0 = PC increments
- pc_target  output  PCWidth  combinational jump target, valid when pc_load=1, else 0
- skip  output  1  combinational: current instruction must not execute (no data/pointer side effects)
- halt  output  1  registered: controller in error state; core must freeze
- err_code  output  2  registered: 0 none, 1 stack overflow, 2 stack underflow, 3 skip overflow / illegal decode
- depth  output  $clog2(Depth+1)  registered: current stack occupancy

Behaviour:
- Clock: clk; reset: synchronous, active-high, port reset.
- Reset: state RUN, sp=0, skip_cnt=0, halt=0, err_code=0, depth=0. pc_load=0, pc_target=0, skip=0 while reset high; reset mid-scan or mid-halt aborts it; stack contents need not clear.
- States: RUN, SKIP, HALT. All decisions are qualified by step; step=0 means outputs pc_load=0, skip=(state==SKIP), no state change.
- RUN, loop_open, !cell_zero:
  - push pc, depth+1, pc_load=0.
  - If depth==Depth: no push, go to HALT, err_code=1.
- RUN, loop_open, cell_zero:
  - no push, skip=1, skip_cnt<=1, go to SKIP, pc_load=0.
- RUN, loop_close, !cell_zero:
  - pc_load=1, pc_target=top+1 (mod 2^PCWidth), stack unchanged.
  - If depth==0: HALT, err_code=2, pc_load=0.
- RUN, loop_close, cell_zero:
  - pop, depth-1, pc_load=0.
  - If depth==0: HALT, err_code=2.
- SKIP (every step):
  - skip=1, pc_load=0.
  - loop_open increments skip_cnt; skip_cnt at all-ones with loop_open goes to HALT, err_code=3.
  - loop_close decrements skip_cnt; reaching 0 returns to RUN next cycle. That close is itself skipped.
  - Stack untouched throughout.
- loop_open and loop_close both high with step=1, any non-HALT state: HALT, err_code=3.
- HALT: sticky until reset. pc_load=0, skip=1, halt=1, err_code held.
- Outputs are a pure function of state + inputs in the same cycle (zero latency to the PC mux). State and halt/err_code/depth update one edge later.
- Neither opcode high: RUN gives pc_load=0, skip=0; SKIP gives skip=1.

Test Plan:
- Simple loop: open@0x0010 with cell nonzero (push), close@0x0014 with cell nonzero -> pc_load=1, pc_target=0x0011. Repeat close with cell_zero -> pc_load=0, depth 1->0.
- Skip scan: open@0x0020 with cell_zero; then nested open/close pair; then close -> skip=1 for all 4 instructions, state RUN after 4th step, depth stays 0, next instruction skip=0.
- Overflow: Depth=16, 16 pushes then 17th open nonzero -> halt=1, err_code=1, depth=16. Further steps ignored until reset, then all outputs 0.
- Underflow: close with depth=0 (both cell values) -> halt=1, err_code=2, pc_load=0.
- Wrap and stall: push 0xFFFF, close nonzero -> pc_target=0x0000. step=0 with close high -> pc_load=0, no state change.
- Reset mid-SKIP with skip_cnt=3 -> next cycle RUN, skip=0, depth=0. Illegal open+close together -> err_code=3.
